// File: rtl/ups_ad.sv
// ups_ad: dual-channel SPI reader for two 12-bit ADCs on a shared sclk/cs_n.
// In: clk, rst_n, start, din0, din1. Out: sclk, cs_n, dv0/data0, dv1/data1, lead_err, busy.
module ups_ad #(
  parameter int HALF_PER   = 8,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12,
  parameter int QUIET_HP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              din0,
  input  logic              din1,
  output logic              sclk,
  output logic              cs_n,
  output logic              dv0,
  output logic [DATA_W-1:0] data0,
  output logic              dv1,
  output logic [DATA_W-1:0] data1,
  output logic              lead_err,
  output logic              busy
);

  localparam int TW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int QW = (QUIET_HP > 1) ? $clog2(QUIET_HP) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(HALF_PER - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QUIET_HP - 1);

  typedef enum logic [2:0] {
    AD_IDLE,
    AD_CS_SETUP,
    AD_SHIFT,
    AD_CS_STOP,
    AD_QUIET
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [QW-1:0]         qc_q, qc_d;
  logic [FRAME_BITS-1:0] sh0_q, sh0_d;
  logic [FRAME_BITS-1:0] sh1_q, sh1_d;
  logic                  sclk_d, cs_n_d, busy_d;
  logic                  dv_d, lerr_d;
  logic [DATA_W-1:0]     data0_d, data1_d;

  // The tick is registered off the timer wrap, so the FSM acts one
  // cycle after the timer reaches its last count.
  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == T_LAST) ? '0 : tmr_q + 1'b1;
    tick_d  = (tmr_q == T_LAST);
    bit_d   = bit_q;
    qc_d    = qc_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sclk_d  = sclk;
    cs_n_d  = cs_n;
    busy_d  = busy;
    dv_d    = 1'b0;
    lerr_d  = 1'b0;
    data0_d = data0;
    data1_d = data1;
    case (state_q)
      AD_IDLE: begin
        tmr_d  = '0;
        tick_d = 1'b0;
        bit_d  = '0;
        qc_d   = '0;
        sclk_d = 1'b1;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sh0_d   = '0;
          sh1_d   = '0;
          state_d = AD_CS_SETUP;
        end
      end
      AD_CS_SETUP: begin
        if (tick_q) begin
          sclk_d  = 1'b0;
          state_d = AD_SHIFT;
        end
      end
      AD_SHIFT: begin
        if (tick_q) begin
          if (sclk) begin
            sclk_d = 1'b0;
          end else begin
            sclk_d = 1'b1;
            sh0_d  = {sh0_q[FRAME_BITS-2:0], din0};
            sh1_d  = {sh1_q[FRAME_BITS-2:0], din1};
            bit_d  = bit_q + 1'b1;
            if (bit_q == B_LAST) begin
              state_d = AD_CS_STOP;
            end
          end
        end
      end
      AD_CS_STOP: begin
        if (tick_q) begin
          cs_n_d  = 1'b1;
          dv_d    = 1'b1;
          data0_d = sh0_q[DATA_W-1:0];
          data1_d = sh1_q[DATA_W-1:0];
          lerr_d  = ((sh0_q >> DATA_W) != '0) ||
                    ((sh1_q >> DATA_W) != '0);
          qc_d    = '0;
          state_d = AD_QUIET;
        end
      end
      AD_QUIET: begin
        if (tick_q) begin
          if (qc_q == Q_LAST) begin
            busy_d  = 1'b0;
            state_d = AD_IDLE;
          end else begin
            qc_d = qc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = AD_IDLE;
        tmr_d   = '0;
        tick_d  = 1'b0;
        bit_d   = '0;
        qc_d    = '0;
        sh0_d   = '0;
        sh1_d   = '0;
        sclk_d  = 1'b1;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        data0_d = '0;
        data1_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= AD_IDLE;
      tmr_q    <= '0;
      tick_q   <= 1'b0;
      bit_q    <= '0;
      qc_q     <= '0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      sclk     <= 1'b1;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      dv0      <= 1'b0;
      dv1      <= 1'b0;
      lead_err <= 1'b0;
      data0    <= '0;
      data1    <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      qc_q     <= qc_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
      sclk     <= sclk_d;
      cs_n     <= cs_n_d;
      busy     <= busy_d;
      dv0      <= dv_d;
      dv1      <= dv_d;
      lead_err <= lerr_d;
      data0    <= data0_d;
      data1    <= data1_d;
    end
  end

endmodule

// File: tb/tb_ups_ad.sv
// tb_ups_ad: directed bench for ups_ad with ADC serial models.
// Instance a uses default timing, instance b uses HALF_PER=2.
module tb_ups_ad;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic din0_a = 1'b0, din1_a = 1'b0;
  logic din0_b = 1'b0, din1_b = 1'b0;
  logic sclk_a, cs_n_a, dv0_a, dv1_a, lerr_a, busy_a;
  logic sclk_b, cs_n_b, dv0_b, dv1_b, lerr_b, busy_b;
  logic [11:0] data0_a, data1_a, data0_b, data1_b;

  logic [15:0] pat0_a = '0, pat1_a = '0;
  logic [15:0] pat0_b = '0, pat1_b = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt_a = 0;
  int rise_a = 0;
  int rise_b = 0;
  int idx_a = 15;
  int idx_b = 15;
  time rb_last = 0;
  time rb_prev = 0;

  ups_ad u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .din0(din0_a), .din1(din1_a),
    .sclk(sclk_a), .cs_n(cs_n_a),
    .dv0(dv0_a), .data0(data0_a),
    .dv1(dv1_a), .data1(data1_a),
    .lead_err(lerr_a), .busy(busy_a)
  );

  ups_ad #(.HALF_PER(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .din0(din0_b), .din1(din1_b),
    .sclk(sclk_b), .cs_n(cs_n_b),
    .dv0(dv0_b), .data0(data0_b),
    .dv1(dv1_b), .data1(data1_b),
    .lead_err(lerr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dv0_a === 1'b1) dv_cnt_a <= dv_cnt_a + 1;
  end

  // ADC models: MSB presented on the first sclk fall, next bit each fall
  always @(negedge sclk_a or posedge cs_n_a) begin
    if (cs_n_a === 1'b1) begin
      idx_a = 15;
    end else if (idx_a >= 0) begin
      din0_a = pat0_a[idx_a];
      din1_a = pat1_a[idx_a];
      idx_a = idx_a - 1;
    end
  end

  always @(negedge sclk_b or posedge cs_n_b) begin
    if (cs_n_b === 1'b1) begin
      idx_b = 15;
    end else if (idx_b >= 0) begin
      din0_b = pat0_b[idx_b];
      din1_b = pat1_b[idx_b];
      idx_b = idx_b - 1;
    end
  end

  always @(posedge sclk_a) begin
    if (cs_n_a === 1'b0) rise_a = rise_a + 1;
  end

  always @(posedge sclk_b) begin
    if (cs_n_b === 1'b0) begin
      rise_b = rise_b + 1;
      rb_prev = rb_last;
      rb_last = $time;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel, output int t0);
    @(negedge clk);
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_dv(input bit sel, input int budget, output int t);
    int n;
    n = 0;
    t = -1;
    while (n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if ((sel ? dv0_b : dv0_a) === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle_a(output int t);
    int n;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    t = cyc;
  endtask

  initial begin
    int t0, t1, t2, t3, tf, n, r0, d0;

    // async reset with no clock edge yet
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pins_a", {sclk_a, cs_n_a, dv0_a, dv1_a, lerr_a, busy_a},
        6'b110000);
    chk("rst_data_a", {data0_a, data1_a}, 24'h0);
    chk("rst_pins_b", {sclk_b, cs_n_b, dv0_b, dv1_b, lerr_b, busy_b},
        6'b110000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_a", {sclk_a, cs_n_a, busy_a}, 3'b110);

    // reset after the 7th sclk rise aborts the frame
    pat0_a = 16'h0ABC;
    pat1_a = 16'h0123;
    r0 = rise_a;
    d0 = dv_cnt_a;
    pulse_start(1'b0, t0);
    chk("accept_busy_cs", {busy_a, cs_n_a}, 2'b10);
    n = 0;
    while (rise_a - r0 < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rise7_reached", rise_a - r0, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pins", {sclk_a, cs_n_a, busy_a, dv0_a, dv1_a}, 5'b11000);
    chk("midrst_data", {data0_a, data1_a}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_no_dv", dv_cnt_a - d0, 0);

    // single frame, no leading bits
    r0 = rise_a;
    pulse_start(1'b0, t0);
    wait_dv(1'b0, 400, t1);
    chk("lat_a", t1 - t0, 265);
    chk("dv1_with_dv0", dv1_a, 1'b1);
    chk("data0_abc", data0_a, 12'hABC);
    chk("data1_123", data1_a, 12'h123);
    chk("lead_err_0", lerr_a, 1'b0);
    @(posedge clk);
    #1;
    chk("dv_one_cycle", {dv0_a, dv1_a}, 2'b00);
    chk("rises_16", rise_a - r0, 16);
    chk("data0_held", data0_a, 12'hABC);
    wait_idle_a(tf);
    chk("busy_fall", tf - t1, 32);

    // leading bit set on ADC0 only
    pat0_a = 16'h8FFF;
    pat1_a = 16'h0000;
    pulse_start(1'b0, t0);
    wait_dv(1'b0, 400, t1);
    chk("data0_fff", data0_a, 12'hFFF);
    chk("data1_000", data1_a, 12'h000);
    chk("lead_err_1", lerr_a, 1'b1);
    @(posedge clk);
    #1;
    chk("lead_err_pulse", lerr_a, 1'b0);
    wait_idle_a(tf);

    // start held high: back-to-back frames
    pat0_a = 16'h0ABC;
    pat1_a = 16'h0123;
    d0 = dv_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    wait_dv(1'b0, 400, t1);
    wait_dv(1'b0, 400, t2);
    chk("dv_spacing_12", t2 - t1, 298);
    n = 0;
    while (cs_n_a !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    tf = cyc;
    start_a = 1'b0;
    chk("cs_high_gap", (tf - t2) >= 32, 1'b1);
    repeat (3) begin
      repeat (50) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_dv(1'b0, 400, t3);
    chk("dv_spacing_23", t3 - t2, 298);
    chk("b2b_data0", data0_a, 12'hABC);
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (400) @(negedge clk);
    chk("b2b_frames", dv_cnt_a - d0, 3);

    // fast instance, HALF_PER=2
    pat0_b = 16'h0555;
    pat1_b = 16'h0AAA;
    r0 = rise_b;
    pulse_start(1'b1, t0);
    wait_dv(1'b1, 200, t1);
    chk("lat_b", t1 - t0, 67);
    chk("data0_b_555", data0_b, 12'h555);
    chk("data1_b_aaa", data1_b, 12'hAAA);
    chk("lead_err_b", lerr_b, 1'b0);
    chk("dv1_b", dv1_b, 1'b1);
    chk("rises_b_16", rise_b - r0, 16);
    chk("sclk_b_period", int'(rb_last - rb_prev), 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
